// File: rtl/neogeo_backup_pkg.sv
// neogeo_backup_pkg: shared FSM state and geometry for the backup RAM SD transfer.
package neogeo_backup_pkg;
  localparam int BKP_SECTOR_WORDS = 256;
  localparam int BKP_SECTORS = 128;
  typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER, NEXT} bkp_state_t;
endpackage

// File: rtl/sd_sector_hs.sv
// sd_sector_hs: per-sector sd_ack edge detector shared by load and save.
module sd_sector_hs (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic xfer,
  input  logic ack,
  output logic start,
  output logic done
);
  logic ack_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ack_q <= 1'b0;
    else ack_q <= ack;
  assign start = req & ack & ~ack_q;
  assign done = xfer & ack_q & ~ack;
endmodule

// File: rtl/backup_sd_ctrl.sv
// backup_sd_ctrl: moves the backup RAM image between port B and the HPS SD interface.
// Define BACKUP_AUTOSAVE_EN to also save automatically once CPU writes go quiet.
module backup_sd_ctrl
  import neogeo_backup_pkg::*;
#(
  parameter int SECTORS = BKP_SECTORS,
  parameter logic [23:0] AUTOSAVE_DELAY = 24'd5_000_000
) (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        save_req,
  input  logic        cpu_write,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic        sd_buff_wr,
  output logic [14:0] sram_addr,
  output logic        sram_wr,
  output logic        busy,
  output logic        dirty
);
  bkp_state_t state, nxt;
  logic pend_load, pend_save, mounted, ro, op_save;
  logic go_load, go_save, drop_save, inc, load_done, auto_go, ack_start, ack_done, last;
  assign last = sd_lba == 32'(SECTORS - 1);
  assign sd_rd = state == LOAD_REQ;
  assign sd_wr = state == SAVE_REQ;
  assign busy = state != IDLE;
  assign sram_addr = {sd_lba[6:0], sd_buff_addr};
  assign sram_wr = sd_buff_wr & sd_ack & (state == LOAD_XFER);
  assign load_done = (state == NEXT) & last & ~pend_load & ~op_save;
  sd_sector_hs u_hs (
    .clk  (clk_sys),
    .rst_n(nRESET),
    .req  (sd_rd | sd_wr),
    .xfer (state == LOAD_XFER || state == SAVE_XFER),
    .ack  (sd_ack),
    .start(ack_start),
    .done (ack_done)
  );
  always_comb begin
    nxt = state;
    go_load = 1'b0;
    go_save = 1'b0;
    drop_save = 1'b0;
    inc = 1'b0;
    case (state)
      IDLE:
        if (pend_load) begin
          nxt = LOAD_REQ;
          go_load = 1'b1;
        end else if (pend_save) begin
          go_save = mounted & ~ro;
          drop_save = ~(mounted & ~ro);
          nxt = go_save ? SAVE_REQ : IDLE;
        end else if (auto_go) begin
          nxt = SAVE_REQ;
          go_save = 1'b1;
        end
      LOAD_REQ:  nxt = ack_start ? LOAD_XFER : LOAD_REQ;
      LOAD_XFER: nxt = ack_done ? NEXT : LOAD_XFER;
      SAVE_REQ:  nxt = ack_start ? SAVE_XFER : SAVE_REQ;
      SAVE_XFER: nxt = ack_done ? NEXT : SAVE_XFER;
      NEXT:
        // a new mount wins over whatever is running, but only between sectors
        if (pend_load) begin
          nxt = LOAD_REQ;
          go_load = 1'b1;
        end else if (last) nxt = IDLE;
        else begin
          nxt = op_save ? SAVE_REQ : LOAD_REQ;
          inc = 1'b1;
        end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge nRESET)
    if (!nRESET) begin
      state <= IDLE;
      pend_load <= 1'b0;
      pend_save <= 1'b0;
      mounted <= 1'b0;
      ro <= 1'b0;
      dirty <= 1'b0;
      op_save <= 1'b0;
      sd_lba <= '0;
    end else begin
      state <= nxt;
      if (img_mounted) begin
        mounted <= |img_size;
        ro <= img_readonly;
      end
      pend_load <= (img_mounted & |img_size) | (pend_load & ~go_load);
      pend_save <= save_req | (pend_save & ~go_save & ~drop_save);
      dirty <= cpu_write | (dirty & ~go_save & ~load_done);
      if (go_load | go_save) begin
        sd_lba <= '0;
        op_save <= go_save;
      end else if (inc) sd_lba <= sd_lba + 32'd1;
    end
`ifdef BACKUP_AUTOSAVE_EN
  logic [23:0] idle_cnt;
  logic armed;
  always_ff @(posedge clk_sys or negedge nRESET)
    if (!nRESET) begin
      idle_cnt <= '0;
      armed <= 1'b0;
    end else begin
      idle_cnt <= cpu_write ? 24'd0 : (idle_cnt == AUTOSAVE_DELAY) ? idle_cnt : idle_cnt + 24'd1;
      armed <= cpu_write | (armed & ~go_save);
    end
  assign auto_go = armed & (idle_cnt == AUTOSAVE_DELAY) & dirty & mounted & ~ro;
`else
  assign auto_go = 1'b0;
`endif
endmodule

// File: tb/tb_backup_sd_ctrl.sv
// tb_backup_sd_ctrl: directed vectors plus an HPS sector model for backup_sd_ctrl.
module tb_backup_sd_ctrl;
  logic clk = 1'b0, nRESET = 1'b0;
  logic img_mounted = 0, img_readonly = 0, save_req = 0, cpu_write = 0;
  logic [63:0] img_size = '0;
  logic sd_ack = 0, sd_buff_wr = 0, sd_rd, sd_wr, sram_wr, busy, dirty;
  logic [7:0] sd_buff_addr = '0;
  logic [31:0] sd_lba;
  logic [14:0] sram_addr;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic hps_en = 0, full = 0;
  int rd_cnt, wr_cnt, seq_err, sw_ok, sw_err, rd_at_wr, wr_at_rd;
  logic [14:0] a305, a100;
  logic last_w;
  logic [31:0] last_l;

  backup_sd_ctrl #(.SECTORS(128), .AUTOSAVE_DELAY(24'd100)) dut (
    .clk_sys(clk), .nRESET(nRESET), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size(img_size), .save_req(save_req), .cpu_write(cpu_write), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_wr(sd_buff_wr), .sram_addr(sram_addr), .sram_wr(sram_wr), .busy(busy), .dirty(dirty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic mnt, nz, ro, save, cpu, ack, bwr;
    logic [7:0] baddr;
    logic [3:0] ef;
    logic [7:0] elba;
    logic [14:0] esa;
    logic esw;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic clr();
    rd_cnt = 0; wr_cnt = 0; seq_err = 0; sw_ok = 0; sw_err = 0;
    rd_at_wr = -1; wr_at_rd = -1; a305 = '0; a100 = '0; last_w = 0; last_l = 127;
  endtask

  task automatic hps();
    logic w;
    logic [31:0] l, el;
    int n;
    forever begin
      @(negedge clk);
      if (hps_en && (sd_rd || sd_wr)) begin
        w = sd_wr;
        l = sd_lba;
        el = (w != last_w || last_l == 127) ? 32'd0 : last_l + 32'd1;
        if (l != el) seq_err++;
        if (w) begin
          if (wr_cnt == 0) rd_at_wr = rd_cnt;
          wr_cnt++;
        end else begin
          if (rd_cnt == 0) wr_at_rd = wr_cnt;
          rd_cnt++;
        end
        last_w = w;
        last_l = l;
        sd_ack = 1;
        n = (full && !w) ? 256 : 4;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          sd_buff_addr = 8'(i);
          sd_buff_wr = full && !w;
          #1;
          if (sd_buff_wr) begin
            if (sram_wr && sram_addr == {el[6:0], 8'(i)}) sw_ok++;
            else sw_err++;
          end else if (sram_wr) sw_err++;
          if (!w && el == 3 && i == 5) a305 = sram_addr;
          if (w && el == 1 && i == 0) a100 = sram_addr;
        end
        @(negedge clk);
        sd_buff_wr = 0;
        sd_ack = 0;
      end
    end
  endtask

  task automatic mount(input logic r, input logic sv);
    @(negedge clk);
    img_mounted = 1; img_size = 64'd65536; img_readonly = r; save_req = sv;
    @(negedge clk);
    img_mounted = 0; save_req = 0;
  endtask

  task automatic pulse_save();
    @(negedge clk); save_req = 1;
    @(negedge clk); save_req = 0;
  endtask

  task automatic pulse_cpu();
    @(negedge clk); cpu_write = 1;
    @(negedge clk); cpu_write = 0;
  endtask

  initial begin
    int c0, bz;
    fork hps(); join_none
    clr();
    //        mnt nz ro sv cpu ack bwr baddr  busy/rd/wr/dirty lba  sram_addr  sram_wr
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 8'd0, 4'b0000, 8'd0, 15'h0000, 0};
    vt[1]  = '{0, 0, 0, 0, 1, 0, 0, 8'd0, 4'b0001, 8'd0, 15'h0000, 0};
    vt[2]  = '{0, 0, 0, 1, 0, 0, 0, 8'd0, 4'b0001, 8'd0, 15'h0000, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 8'd0, 4'b0001, 8'd0, 15'h0000, 0};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 8'd0, 4'b0001, 8'd0, 15'h0000, 0};
    vt[5]  = '{1, 1, 0, 0, 0, 0, 0, 8'd0, 4'b0001, 8'd0, 15'h0000, 0};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 8'd0, 4'b1101, 8'd0, 15'h0000, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 8'd0, 4'b1101, 8'd0, 15'h0000, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 1, 0, 8'd0, 4'b1001, 8'd0, 15'h0000, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 1, 1, 8'd5, 4'b1001, 8'd0, 15'h0005, 1};
    vt[10] = '{0, 0, 0, 0, 0, 1, 0, 8'd5, 4'b1001, 8'd0, 15'h0005, 0};
    vt[11] = '{0, 0, 0, 0, 0, 0, 0, 8'd0, 4'b1001, 8'd0, 15'h0000, 0};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 8'd0, 4'b1101, 8'd1, 15'h0100, 0};
    vt[13] = '{0, 0, 0, 0, 0, 1, 0, 8'd0, 4'b1001, 8'd1, 15'h0100, 0};
    repeat (3) @(negedge clk);
    nRESET = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      img_mounted = vt[i].mnt; img_size = vt[i].nz ? 64'd65536 : 64'd0; img_readonly = vt[i].ro;
      save_req = vt[i].save; cpu_write = vt[i].cpu; sd_ack = vt[i].ack;
      sd_buff_wr = vt[i].bwr; sd_buff_addr = vt[i].baddr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {busy, sd_rd, sd_wr, dirty, sd_lba, sram_addr, sram_wr},
          {vt[i].ef, 32'(vt[i].elba), vt[i].esa, vt[i].esw});
    end
    @(negedge clk);
    img_mounted = 0; save_req = 0; cpu_write = 0; sd_buff_wr = 0;
    nRESET = 0;
    #1;
    chk("async_reset", {busy, sd_rd, sd_wr, dirty, sd_lba}, 36'h0);
    sd_ack = 0; sd_buff_addr = 0;
    @(negedge clk);
    nRESET = 1;
    hps_en = 1;

    // full load with every word strobed
    clr(); full = 1;
    pulse_cpu();
    mount(0, 0);
    for (int k = 0; k < 40000 && !(rd_cnt == 128 && !busy); k++) @(negedge clk);
    chk("load_done", 64'(rd_cnt == 128 && !busy), 64'd1);
    chk("load_seq", 64'(seq_err), 64'd0);
    chk("load_strobes", 64'(sw_ok), 64'd32768);
    chk("load_strobe_err", 64'(sw_err), 64'd0);
    chk("load_s3w5", 64'(a305), 64'h0305);
    chk("load_no_wr", 64'(wr_cnt), 64'd0);
    chk("load_dirty", 64'(dirty), 64'd0);
    full = 0;

    // save; a CPU write in the last sector leaves the RAM dirty afterwards
    clr();
    pulse_save();
    for (int k = 0; k < 3000 && !(busy && sd_lba == 127); k++) @(negedge clk);
    pulse_cpu();
    for (int k = 0; k < 3000 && !(wr_cnt == 128 && !busy); k++) @(negedge clk);
    chk("save_done", 64'(wr_cnt == 128 && !busy), 64'd1);
    chk("save_no_rd", 64'(rd_cnt), 64'd0);
    chk("save_seq", 64'(seq_err), 64'd0);
    chk("save_s1w0", 64'(a100), 64'h0100);
    chk("save_dirty_kept", 64'(dirty), 64'd1);
    pulse_save();
    for (int k = 0; k < 3000 && !(wr_cnt == 256 && !busy); k++) @(negedge clk);
    chk("save2_done", 64'(wr_cnt == 256 && !busy), 64'd1);
    chk("save2_dirty", 64'(dirty), 64'd0);

    // read-only image: save request is dropped
    clr();
    mount(1, 0);
    for (int k = 0; k < 3000 && !(rd_cnt == 128 && !busy); k++) @(negedge clk);
    chk("ro_load_done", 64'(rd_cnt), 64'd128);
    pulse_save();
    bz = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) bz++;
    end
    chk("ro_busy", 64'(bz), 64'd0);
    chk("ro_no_wr", 64'(wr_cnt), 64'd0);

    // mount and save together: full load, then full save
    clr();
    pulse_cpu();
    mount(0, 1);
    for (int k = 0; k < 6000 && !(wr_cnt == 128 && !busy); k++) @(negedge clk);
    chk("both_wr", 64'(wr_cnt), 64'd128);
    chk("both_rd", 64'(rd_cnt), 64'd128);
    chk("both_order", 64'(rd_at_wr), 64'd128);
    chk("both_seq", 64'(seq_err), 64'd0);
    chk("both_dirty", 64'(dirty), 64'd0);

    // mount during sector 40 of a save: sector 40 completes, then load restarts at 0
    clr();
    pulse_save();
    for (int k = 0; k < 3000 && !(sd_wr && sd_lba == 40); k++) @(negedge clk);
    mount(0, 0);
    for (int k = 0; k < 6000 && !(rd_cnt == 128 && !busy); k++) @(negedge clk);
    chk("abort_wr", 64'(wr_cnt), 64'd41);
    chk("abort_order", 64'(wr_at_rd), 64'd41);
    chk("abort_rd", 64'(rd_cnt), 64'd128);
    chk("abort_seq", 64'(seq_err), 64'd0);

    // idle-time autosave
    clr();
    pulse_cpu();
    c0 = cyc;
    repeat (48) @(negedge clk);
    pulse_cpu();
    for (int k = 0; k < 300 && !sd_wr; k++) @(negedge clk);
`ifdef BACKUP_AUTOSAVE_EN
    chk("auto_start", 64'(cyc - c0), 64'd151);
    chk("auto_dirty", 64'(dirty), 64'd0);
    for (int k = 0; k < 3000 && !(wr_cnt == 128 && !busy); k++) @(negedge clk);
    chk("auto_done", 64'(wr_cnt), 64'd128);
`else
    chk("no_auto_wr", 64'(sd_wr), 64'd0);
    chk("no_auto_cnt", 64'(wr_cnt), 64'd0);
    chk("no_auto_dirty", 64'(dirty), 64'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
